vram_port_b_ctrl: RTL and testbench
===================================

# vram_port_b_ctrl

Sequencer for port B of one PPU VRAM block (tile, pattern, palette or sprite RAM). It accepts write, read and fill commands over a valid/ready handshake and drives the RAM's port B address, write data, byte-enable and write-enable. It also returns read data with fixed latency. The VRAM top instantiates one per RAM, sized by parameters, as the CPU-side writer/reader for the RAMs whose port A is owned by the PPU render pipeline.

## Interface
- `ADDR_W`, 11: RAM word-address width.
- `DATA_W`, 64: RAM word width; `BE_W = DATA_W/8`.
- `RD_LAT`, 2: RAM read latency in cycles, from address registered to `ram_rddata` valid.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 2: 0 = WRITE, 1 = READ, 2 = FILL, 3 = reserved (treated as NOP, accepted, no RAM access).
- `cmd_addr` in `ADDR_W`: start word address.
- `cmd_data` in `DATA_W`: write/fill data.
- `cmd_byteena` in `BE_W`: byte enables for WRITE/FILL.
- `cmd_len` in `ADDR_W`: FILL word count minus 1.
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid.
- `rd_data` out `DATA_W`: read result, registered.
- `busy` out 1: FILL in progress or any read in flight.
- `ram_addr` out `ADDR_W`: to RAM `address_b`.
- `ram_wrdata` out `DATA_W`: to RAM `data_b`.
- `ram_byteena` out `BE_W`: to RAM `byteena_b`.
- `ram_wren` out 1: to RAM `wren_b`.
- `ram_rddata` in `DATA_W`: from RAM `q_b`.

## Operation
- FSM states: IDLE, FILL. `cmd_ready = (state == IDLE)`.
- Reset values:
  - `state` = IDLE.
  - `cmd_ready` = 1 in the first cycle after reset.
  - `ram_wren`, `rd_valid`, `busy` = 0.
  - `ram_addr`, `ram_wrdata`, `rd_data` = 0.
  - `ram_byteena` = all ones.
  - Read-tag shift register cleared.
- WRITE accepted in IDLE: next cycle `ram_wren` = 1 with the command's addr, data and byteena for exactly one cycle. Stays in IDLE, so back-to-back writes run at one per cycle.
- READ accepted in IDLE: next cycle `ram_wren` = 0 and `ram_addr` = `cmd_addr`. A tag enters an `RD_LAT+1`-deep shift register. When the tag exits, `rd_data <= ram_rddata` and `rd_valid` pulses. Reads pipeline at one per cycle. Results return in issue order.
- FILL accepted in IDLE: load the remaining count with `cmd_len` and go to FILL.
  - Each FILL cycle writes `cmd_data`/`cmd_byteena` at the current address, then increments the address.
  - The address wraps mod 2^`ADDR_W` (0x7FF→0x000 at default).
  - When the count is 0 in a write cycle, the next state is IDLE. A FILL therefore performs `cmd_len+1` writes.
- Reads in flight when a FILL or WRITE is accepted still complete normally. Read and write of the same address on port B in adjacent cycles return old or new data per the RAM's own read-during-write mode. This block does not forward.
- Idle cycles: `ram_wren` = 0. `ram_addr` holds its last value.
- `reset` asserted mid-FILL: the write stops in the reset cycle and `ram_wren` is 0 on the next cycle. In-flight read tags are dropped and no `rd_valid` follows.

## Timing
- Command accepted at edge n (cycle n = valid&ready).
- WRITE: RAM write in cycle n+1.
- READ: `ram_addr` in cycle n+1, `rd_valid`/`rd_data` in cycle n+2+`RD_LAT` (cycle n+4 at default).
- FILL: writes in cycles n+1 … n+1+`cmd_len`. `cmd_ready` is 0 in those cycles and 1 again in cycle n+2+`cmd_len`.
- `busy` is combinational: `state == FILL || |read_tags`.

## Configuration
- `VRAM_PORTB_FILL_EN` defined: FILL supported as above.
- Undefined: no FILL state or counter. `cmd_op` = 2 behaves exactly as WRITE (one word, `cmd_len` ignored), and `cmd_ready` is constantly 1 outside reset.

## Structure
- Shared package `vram_pkg`:
  - `vram_op_e` enum (WRITE, READ, FILL, NOP).
  - Per-RAM `*_ADDR_W`/`*_DATA_W` constants for tile, pattern, palette and sprite RAM, used by the VRAM top when instantiating.
- One natural sub-module: `vram_rd_tag_pipe`, a parameterised `RD_LAT+1` valid shift register with synchronous clear.

## Test plan
- WRITE addr 0x010, data 0x0123456789ABCDEF, byteena 0xFF, then READ 0x010 → `ram_wren` 1 for one cycle. `rd_valid` in acceptance cycle+4 with `rd_data` 0x0123456789ABCDEF.
- WRITE 0x020 data all-ones byteena 0xFF, then WRITE 0x020 data 0 byteena 0x0F, then READ 0x020 → `rd_data` 0xFFFFFFFF00000000.
- Four back-to-back READs 0x000–0x003 of preloaded values 0xA0–0xA3 → four consecutive `rd_valid` cycles, data in order. `cmd_ready` stays 1.
- FILL addr 0x7FE, len 3, data 0x55…55 → writes at 0x7FE, 0x7FF, 0x000, 0x001. `cmd_ready` is 0 for exactly 4 cycles. A READ held during the FILL is accepted in the cycle after.
- FILL len 0x100, `reset` pulsed after 10 writes → no `ram_wren` after reset. Words 0x00A onward unchanged. `cmd_ready` = 1, `busy` = 0.
- With `VRAM_PORTB_FILL_EN` undefined: FILL len 5 at 0x040 → a single write at 0x040, and 0x041 unchanged on readback.

Source files
------------

// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the PPU VRAM block:
//   - vram_op_e        : port-B command opcodes
//   - portb_state_e    : port-B sequencer states
//   - per-RAM address/data widths used when the VRAM top instantiates one
//     vram_port_b_ctrl per RAM (tile, pattern, palette, sprite)
// No ports (package only).
// -----------------------------------------------------------------------------
package vram_pkg;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    READ  = 2'd1,
    FILL  = 2'd2,
    NOP   = 2'd3
  } vram_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } portb_state_e;

  localparam int TILE_ADDR_W    = 11;
  localparam int TILE_DATA_W    = 64;
  localparam int PATTERN_ADDR_W = 12;
  localparam int PATTERN_DATA_W = 64;
  localparam int PALETTE_ADDR_W = 8;
  localparam int PALETTE_DATA_W = 32;
  localparam int SPRITE_ADDR_W  = 8;
  localparam int SPRITE_DATA_W  = 64;

  // Byte-enable width for a RAM word of the given data width.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// vram_rd_tag_pipe
// Valid-bit shift register that tracks reads in flight through the RAM.
// A tag enters at stage 0 and leaves DEPTH cycles later; clr drops all tags
// synchronously.
// Ports:
//   clk        in  : clock
//   clr        in  : synchronous clear, active high
//   in_valid   in  : a read was issued this cycle
//   out_valid  out : the oldest tag is in the last stage (data is due now)
//   any_valid  out : at least one tag is in flight
// -----------------------------------------------------------------------------
module vram_rd_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic in_valid,
  output logic out_valid,
  output logic any_valid
);

  logic [DEPTH-1:0] tags_q;
  logic [DEPTH-1:0] tags_d;

  // Shift every tag one stage towards the exit, new tag at stage 0.
  always_comb begin
    tags_d = {tags_q[DEPTH-2:0], in_valid};
  end

  // Tag register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      tags_q <= {DEPTH{1'b0}};
    end else begin
      tags_q <= tags_d;
    end
  end

  assign out_valid = tags_q[DEPTH-1];
  assign any_valid = |tags_q;

endmodule

// File: rtl/vram_port_b_ctrl.sv
// -----------------------------------------------------------------------------
// vram_port_b_ctrl
// CPU-side sequencer for port B of one VRAM block. Accepts WRITE, READ, FILL
// and NOP commands over valid/ready and drives the RAM's port B. Read data
// returns RD_LAT+2 cycles after acceptance, in issue order.
//
// Build option: define VRAM_PORTB_FILL_EN to enable multi-word FILL. Without
// it there is no FILL state or counter, FILL acts as a single WRITE and
// cmd_ready is 1 whenever reset is low.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake
//   cmd_op           : 0 WRITE, 1 READ, 2 FILL, 3 NOP
//   cmd_addr         : start word address
//   cmd_data         : write/fill word
//   cmd_byteena      : byte enables for WRITE/FILL
//   cmd_len          : FILL word count minus one
//   rd_valid/rd_data : registered read return (one-cycle pulse)
//   busy             : FILL running or reads in flight
//   ram_addr/ram_wrdata/ram_byteena/ram_wren : to RAM port B
//   ram_rddata       : from RAM port B
// -----------------------------------------------------------------------------
module vram_port_b_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic [DATA_W/8-1:0]   cmd_byteena,
  input  logic [ADDR_W-1:0]     cmd_len,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wrdata,
  output logic [DATA_W/8-1:0]   ram_byteena,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     ram_rddata
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]   ram_addr_q,    ram_addr_d;
  logic [DATA_W-1:0]   ram_wrdata_q,  ram_wrdata_d;
  logic [DATA_W/8-1:0] ram_byteena_q, ram_byteena_d;
  logic                ram_wren_q,    ram_wren_d;
  logic [DATA_W-1:0]   rd_data_q,     rd_data_d;
  logic                rd_valid_q,    rd_valid_d;

  logic                cmd_accept_s;
  logic                rd_issue_s;
  logic                tag_exit_s;
  logic                tag_any_s;
  vram_op_e            cmd_op_s;

`ifdef VRAM_PORTB_FILL_EN
  portb_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q == ST_FILL) || tag_any_s;
`else
  logic                unused_len_s;

  assign unused_len_s = ^cmd_len;
  assign cmd_ready    = !reset;
  assign busy         = tag_any_s;
`endif

  assign cmd_accept_s = cmd_valid && cmd_ready;
  assign cmd_op_s     = vram_op_e'(cmd_op);

  // Command decode and FILL sequencing; RAM port outputs hold by default.
  always_comb begin
    ram_addr_d    = ram_addr_q;
    ram_wrdata_d  = ram_wrdata_q;
    ram_byteena_d = ram_byteena_q;
    ram_wren_d    = 1'b0;
    rd_issue_s    = 1'b0;
`ifdef VRAM_PORTB_FILL_EN
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
`endif
    if (cmd_accept_s) begin
      case (cmd_op_s)
        WRITE: begin
          ram_addr_d    = cmd_addr;
          ram_wrdata_d  = cmd_data;
          ram_byteena_d = cmd_byteena;
          ram_wren_d    = 1'b1;
        end
        READ: begin
          ram_addr_d = cmd_addr;
          rd_issue_s = 1'b1;
        end
        FILL: begin
          // The first fill word goes out in the cycle right after acceptance,
          // so the FILL state only has to step the remaining words.
          ram_addr_d    = cmd_addr;
          ram_wrdata_d  = cmd_data;
          ram_byteena_d = cmd_byteena;
          ram_wren_d    = 1'b1;
`ifdef VRAM_PORTB_FILL_EN
          state_d       = ST_FILL;
          fill_cnt_d    = cmd_len;
`endif
        end
        NOP: begin
          ram_wren_d = 1'b0;
        end
        default: begin
          ram_wren_d = 1'b0;
        end
      endcase
    end else begin
`ifdef VRAM_PORTB_FILL_EN
      case (state_q)
        ST_FILL: begin
          // fill_cnt_q counts words still to write after the current one.
          if (fill_cnt_q == ADDR_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            ram_addr_d = ram_addr_q + ADDR_ONE;
            ram_wren_d = 1'b1;
            fill_cnt_d = fill_cnt_q - ADDR_ONE;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
`else
      ram_wren_d = 1'b0;
`endif
    end
  end

  // Read return: capture RAM data when the oldest tag leaves the pipe.
  always_comb begin
    rd_valid_d = tag_exit_s;
    if (tag_exit_s) begin
      rd_data_d = ram_rddata;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q    <= ADDR_ZERO;
      ram_wrdata_q  <= {DATA_W{1'b0}};
      ram_byteena_q <= {(DATA_W/8){1'b1}};
      ram_wren_q    <= 1'b0;
      rd_data_q     <= {DATA_W{1'b0}};
      rd_valid_q    <= 1'b0;
`ifdef VRAM_PORTB_FILL_EN
      state_q       <= ST_IDLE;
      fill_cnt_q    <= ADDR_ZERO;
`endif
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_wrdata_q  <= ram_wrdata_d;
      ram_byteena_q <= ram_byteena_d;
      ram_wren_q    <= ram_wren_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
`ifdef VRAM_PORTB_FILL_EN
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
`endif
    end
  end

  vram_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .clr       (reset),
    .in_valid  (rd_issue_s),
    .out_valid (tag_exit_s),
    .any_valid (tag_any_s)
  );

  // A write scheduled for the reset cycle is suppressed so a FILL stops
  // immediately instead of one word late.
  assign ram_wren    = ram_wren_q && !reset;
  assign ram_addr    = ram_addr_q;
  assign ram_wrdata  = ram_wrdata_q;
  assign ram_byteena = ram_byteena_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_vram_port_b_ctrl.sv
`timescale 1ns/1ps
module tb_vram_port_b_ctrl;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 2048;
  localparam int MAXC   = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd3;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [BE_W-1:0]   cmd_byteena = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wrdata;
  logic [BE_W-1:0]   ram_byteena;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rddata;

  always #5 clk = ~clk;

  vram_port_b_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_byteena(cmd_byteena), .cmd_len(cmd_len), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .ram_addr(ram_addr),
    .ram_wrdata(ram_wrdata), .ram_byteena(ram_byteena), .ram_wren(ram_wren),
    .ram_rddata(ram_rddata)
  );

  // ---------------- RAM behavioural model (environment) ----------------
  logic [DATA_W-1:0] ram_mem  [DEPTH];
  logic [DATA_W-1:0] ram_pipe [RD_LAT];

  function automatic logic [DATA_W-1:0] preload(input int i);
    if (i < 4) return 64'hA0 + 64'(i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wrdata, ram_byteena);
    ram_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rddata = ram_pipe[RD_LAT-1];

  // ---------------- reference model: per-cycle expected events ----------------
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  bit                e_wr [MAXC];
  bit                e_av [MAXC];
  logic [ADDR_W-1:0] e_aa [MAXC];
  logic [DATA_W-1:0] e_wd [MAXC];
  logic [BE_W-1:0]   e_wb [MAXC];
  bit                e_rv [MAXC];
  logic [DATA_W-1:0] e_rd [MAXC];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int fill_end = -1;   // last cycle a FILL occupies the port
  int rd_end = -1;     // last cycle a read tag is in flight
  logic [ADDR_W-1:0] hold_addr = '0;

  logic [DATA_W-1:0] rd_log [$];
  int                rd_cyc [$];
  int                low_cnt = 0;
  int                wr_cnt = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic sched_write(input int c, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    e_wr[c] = 1'b1; e_av[c] = 1'b1; e_aa[c] = a; e_wd[c] = d; e_wb[c] = b;
  endtask

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    bit exp_ready;
    bit exp_busy;
    if (reset) begin
      chk("wren_in_reset", 64'(ram_wren), 64'd0);
      for (int k = cyc + 1; k < MAXC; k++) begin
        e_wr[k] = 1'b0; e_av[k] = 1'b0; e_rv[k] = 1'b0;
      end
      fill_end = -1;
      rd_end = -1;
      hold_addr = '0;
    end else begin
      exp_ready = (cyc > fill_end);
      exp_busy  = (cyc <= fill_end) || (cyc <= rd_end);
      if (e_av[cyc]) hold_addr = e_aa[cyc];
      chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("ram_wren", 64'(ram_wren), 64'(e_wr[cyc]));
      chk("ram_addr", 64'(ram_addr), 64'(hold_addr));
      if (e_wr[cyc]) begin
        chk("ram_wrdata", ram_wrdata, e_wd[cyc]);
        chk("ram_byteena", 64'(ram_byteena), 64'(e_wb[cyc]));
        mdl_mem[e_aa[cyc]] = merge(mdl_mem[e_aa[cyc]], e_wd[cyc], e_wb[cyc]);
      end
      chk("rd_valid", 64'(rd_valid), 64'(e_rv[cyc]));
      if (e_rv[cyc]) chk("rd_data", rd_data, e_rd[cyc]);
      if (rd_valid) begin
        rd_log.push_back(rd_data);
        rd_cyc.push_back(cyc);
      end
      if (!cmd_ready) low_cnt++;
      if (ram_wren) wr_cnt++;
      if (cmd_valid && exp_ready) begin
        case (cmd_op)
          2'd0: sched_write(cyc + 1, cmd_addr, cmd_data, cmd_byteena);
          2'd1: begin
            e_av[cyc+1] = 1'b1;
            e_aa[cyc+1] = cmd_addr;
            e_rv[cyc+2+RD_LAT] = 1'b1;
            e_rd[cyc+2+RD_LAT] = mdl_mem[cmd_addr];
            rd_end = cyc + 1 + RD_LAT;
          end
          2'd2: begin
`ifdef VRAM_PORTB_FILL_EN
            for (int i = 0; i <= int'(cmd_len); i++)
              sched_write(cyc + 1 + i, cmd_addr + ADDR_W'(i), cmd_data, cmd_byteena);
            fill_end = cyc + 1 + int'(cmd_len);
`else
            sched_write(cyc + 1, cmd_addr, cmd_data, cmd_byteena);
`endif
          end
          default: ;
        endcase
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                       input logic [ADDR_W-1:0] len, output time t_acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    cmd_byteena = be; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL handshake_timeout op=%0d got_ready=0 want_ready=1", op);
    end
    t_acc = $time;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1;
    int n0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = preload(i);
      mdl_mem[i] = preload(i);
    end
    for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wrdata", ram_wrdata, 64'd0);
    chk("rst_byteena", 64'(ram_byteena), 64'hFF);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;

    // write then read back
    n0 = rd_log.size();
    issue(2'd0, 11'h010, 64'h0123_4567_89AB_CDEF, 8'hFF, 11'd0, t0);
    issue(2'd1, 11'h010, 64'd0, 8'h00, 11'd0, t1);
    idle(6);
    chk("wr_rd_count", 64'(rd_log.size()), 64'(n0 + 1));
    if (rd_log.size() > n0) chk("wr_rd_data", rd_log[n0], 64'h0123_4567_89AB_CDEF);

    // byte-enabled partial overwrite
    n0 = rd_log.size();
    issue(2'd0, 11'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 11'd0, t0);
    issue(2'd0, 11'h020, 64'd0, 8'h0F, 11'd0, t0);
    issue(2'd1, 11'h020, 64'd0, 8'h00, 11'd0, t1);
    idle(6);
    if (rd_log.size() > n0) chk("be_merge", rd_log[n0], 64'hFFFF_FFFF_0000_0000);
    else chk("be_merge_count", 64'(rd_log.size()), 64'(n0 + 1));

    // four back-to-back reads
    n0 = rd_log.size();
    for (int i = 0; i < 4; i++) issue(2'd1, ADDR_W'(i), 64'd0, 8'h00, 11'd0, t1);
    idle(6);
    chk("b2b_count", 64'(rd_log.size()), 64'(n0 + 4));
    if (rd_log.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) chk("b2b_data", rd_log[n0+i], 64'hA0 + 64'(i));
      chk("b2b_consecutive", 64'(rd_cyc[n0+3] - rd_cyc[n0]), 64'd3);
    end

    // NOP: accepted, no RAM access
    wr_cnt = 0;
    issue(2'd3, 11'h123, 64'h1, 8'hFF, 11'd0, t0);
    idle(3);
    chk("nop_no_write", 64'(wr_cnt), 64'd0);

    // reset with a read in flight drops the result
    n0 = rd_log.size();
    issue(2'd1, 11'h003, 64'd0, 8'h00, 11'd0, t1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    idle(6);
    chk("rst_drop_read", 64'(rd_log.size()), 64'(n0));

`ifdef VRAM_PORTB_FILL_EN
    // wrapping FILL with a READ waiting behind it
    low_cnt = 0;
    n0 = rd_log.size();
    issue(2'd2, 11'h7FE, {8{8'h55}}, 8'hFF, 11'd3, t0);
    issue(2'd1, 11'h7FF, 64'd0, 8'h00, 11'd0, t1);
    idle(6);
    chk("fill_ready_low", 64'(low_cnt), 64'd4);
    chk("fill_read_slot", 64'(t1 - t0), 64'd50);
    chk("fill_7fe", ram_mem[11'h7FE], {8{8'h55}});
    chk("fill_7ff", ram_mem[11'h7FF], {8{8'h55}});
    chk("fill_000", ram_mem[11'h000], {8{8'h55}});
    chk("fill_001", ram_mem[11'h001], {8{8'h55}});
    chk("fill_002_kept", ram_mem[11'h002], 64'hA2);
    if (rd_log.size() > n0) chk("fill_readback", rd_log[n0], {8{8'h55}});

    // long FILL cut by reset after 10 writes
    wr_cnt = 0;
    issue(2'd2, 11'h000, 64'h3C3C_3C3C_3C3C_3C3C, 8'hFF, 11'h100, t0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("cut_ready", 64'(cmd_ready), 64'd1);
    chk("cut_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    idle(4);
    chk("cut_writes", 64'(wr_cnt), 64'd10);
    chk("cut_009", ram_mem[11'h009], 64'h3C3C_3C3C_3C3C_3C3C);
    chk("cut_00a", ram_mem[11'h00A], 64'hC0DE_0000_0000_000A);
    issue(2'd1, 11'h00A, 64'd0, 8'h00, 11'd0, t1);
    idle(6);
`else
    // FILL degenerates to a single WRITE
    wr_cnt = 0;
    n0 = rd_log.size();
    issue(2'd2, 11'h040, 64'h5A5A_0000_1234_5678, 8'hFF, 11'd5, t0);
    issue(2'd1, 11'h040, 64'd0, 8'h00, 11'd0, t1);
    issue(2'd1, 11'h041, 64'd0, 8'h00, 11'd0, t1);
    idle(6);
    chk("nofill_writes", 64'(wr_cnt), 64'd1);
    chk("nofill_count", 64'(rd_log.size()), 64'(n0 + 2));
    if (rd_log.size() >= n0 + 2) begin
      chk("nofill_040", rd_log[n0], 64'h5A5A_0000_1234_5678);
      chk("nofill_041", rd_log[n0+1], 64'hC0DE_0000_0000_0041);
    end
`endif

    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
